dds_avalon_mm_config_master: RTL
================================

// Module: dds_avalon_mm_config_master
// PURPOSE
//  Avalon-MM master that loads a complete DDS configuration into the DDS register slave:
//  coarse_step table (addr 0..N_STEPS-1), tipo_ajuste (TIPO_ADDR), enable (ENABLE_ADDR).
//  Optional read-back verify before enabling. Sits between local control logic (or a
//  soft-CPU-free boot path) and the DDS slave port on the same Avalon-MM fabric.
// PARAMETERS
//  N_STEPS      16   number of coarse_step words written, addresses 0..N_STEPS-1
//  DATA_W       32   Avalon data width
//  ADDR_W       5    Avalon word-address width
//  TIPO_ADDR    17   address of tipo_ajuste register
//  ENABLE_ADDR  16   address of enable register
//  TIMEOUT      255  max consecutive waitrequest cycles per transfer before abort
// PORTS
//  clock            in   1              clock
//  reset            in   1              reset, asynchronous, active-high
//  start            in   1              1-cycle request to run a configuration sequence
//  i_step_table     in   DATA_W x N_STEPS  coarse_step words, index = target address
//  i_tipo_ajuste    in   1              value written to TIPO_ADDR (bit 0)
//  i_enable         in   1              value written to ENABLE_ADDR (bit 0)
//  i_verify         in   1              1 = read back and compare before enable write
//  o_busy           out  1              sequence in progress
//  o_done           out  1              1-cycle pulse at end of sequence (pass or fail)
//  o_error          out  1              sticky until next accepted start: mismatch or timeout
//  o_error_addr     out  ADDR_W         address of first failing transfer
//  avm_address      out  ADDR_W         Avalon word address
//  avm_chipselect   out  1              asserted with every read/write
//  avm_write        out  1              write strobe
//  avm_read         out  1              read strobe
//  avm_writedata    out  DATA_W         write data; bits above bit 0 zero for tipo/enable
//  avm_readdata     in   DATA_W         read data, valid in cycle read && !waitrequest
//  avm_waitrequest  in   1              slave stall; tie 0 for zero-wait slave
// BEHAVIOUR
//  Reset: all outputs 0; FSM -> IDLE; counters 0. Reset mid-sequence drops strobes at once.
//  start accepted only in IDLE; start while busy ignored. On accept: snapshot all i_* into
//   local regs, clear o_error/o_error_addr, o_busy=1 next cycle.
//  FSM: IDLE -> WR_TAB -> WR_TIPO -> [RD_TAB -> RD_TIPO if verify] -> WR_EN -> DONE -> IDLE.
//   WR_TAB: write snapshot[k] to addr k, k=0..N_STEPS-1.  WR_TIPO: {0,tipo} to TIPO_ADDR.
//   RD_TAB/RD_TIPO: read same addresses; compare full word (tipo: full word vs {0,tipo}).
//   WR_EN: {0,enable} to ENABLE_ADDR, issued only if no error so far.
//   DONE: o_done=1 one cycle, o_busy=0 in the same cycle; back to IDLE.
//  Handshake: address/data/strobes held constant while waitrequest=1; transfer completes in
//   the cycle strobe && !waitrequest; next transfer driven the following cycle (no idle gap).
//   Never read and write in the same cycle; chipselect==read|write.
//  Mismatch: first mismatching read sets o_error, o_error_addr=that addr; remaining reads
//   still performed (error_addr not overwritten); WR_EN skipped -> DONE.
//  Timeout: wait counter resets each new transfer; TIMEOUT consecutive stalled cycles ->
//   drop strobes, o_error=1, o_error_addr=current addr, go to DONE (enable never written).
//  Latency, zero-wait slave: verify=0 -> N_STEPS+2 transfer cycles, verify=1 ->
//   2*N_STEPS+3; o_done in the cycle after the last transfer completes.
//  Address counter wraps nowhere: terminates exactly at N_STEPS-1.
// TESTING
//  T1 zero-wait, verify=0, table[k]=32'hA000_0000+k, tipo=1, en=1, start -> writes 0..15,17,16
//     in 18 consecutive cycles; o_done at cycle 19; slave regs match; o_error=0.
//  T2 verify=1, slave model corrupts addr 5 read (xor 1) -> 16+1 writes, 17 reads, no write
//     to 16; o_error=1, o_error_addr=5, o_done pulses once.
//  T3 random waitrequest (50%, max 10 cycles) -> strobes/addr/data stable while stalled;
//     same final slave contents as T1; no transfer lost or duplicated.
//  T4 waitrequest stuck 1 on addr 3 -> abort after 255 stalled cycles; o_error_addr=3;
//     enable reg remains 0.
//  T5 start pulse during busy and i_step_table changed mid-run -> ignored; written data = snapshot.
//  T6 reset asserted at transfer 8 -> strobes 0 immediately, o_busy=0; new start runs from addr 0.

Source files
------------

// File: rtl/dds_avalon_mm_config_master.sv
// Avalon-MM master that loads the coarse_step table, tipo_ajuste and enable into the DDS
// register slave, with optional read-back verify before the enable write.
module dds_avalon_mm_config_master #(
   parameter int N_STEPS     = 16,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int TIPO_ADDR   = 17,
   parameter int ENABLE_ADDR = 16,
   parameter int TIMEOUT     = 255
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [N_STEPS-1:0][DATA_W-1:0] i_step_table,
   input  logic                           i_tipo_ajuste,
   input  logic                           i_enable,
   input  logic                           i_verify,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_error,
   output logic [ADDR_W-1:0]              o_error_addr,
   output logic [ADDR_W-1:0]              avm_address,
   output logic                           avm_chipselect,
   output logic                           avm_write,
   output logic                           avm_read,
   output logic [DATA_W-1:0]              avm_writedata,
   input  logic [DATA_W-1:0]              avm_readdata,
   input  logic                           avm_waitrequest
);

   localparam int IDX_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_STEPS - 1);
   localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE, WR_TAB, WR_TIPO, RD_TAB, RD_TIPO, WR_EN, DONE
   } state_t;

   state_t                         state, state_nxt;
   logic [IDX_W-1:0]               idx, idx_nxt;
   logic [WAIT_W-1:0]              wait_cnt, wait_nxt;
   logic [N_STEPS-1:0][DATA_W-1:0] table_q;
   logic                           tipo_q, enable_q, verify_q;
   logic                           accept, fail;
   logic [DATA_W-1:0]              expected;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Inputs are captured once so a mid-run change cannot leak into the sequence.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         table_q  <= '0;
         tipo_q   <= 1'b0;
         enable_q <= 1'b0;
         verify_q <= 1'b0;
      end else if (accept) begin
         table_q  <= i_step_table;
         tipo_q   <= i_tipo_ajuste;
         enable_q <= i_enable;
         verify_q <= i_verify;
      end
   end

   // Only the first failing transfer is recorded until the next accepted start.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         o_error      <= 1'b0;
         o_error_addr <= '0;
      end else if (accept) begin
         o_error      <= 1'b0;
         o_error_addr <= '0;
      end else if (fail && !o_error) begin
         o_error      <= 1'b1;
         o_error_addr <= avm_address;
      end
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = idx;
      wait_nxt      = wait_cnt;
      accept        = 1'b0;
      fail          = 1'b0;
      expected      = '0;
      avm_write     = 1'b0;
      avm_read      = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      o_done        = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = WR_TAB;
               idx_nxt   = '0;
               wait_nxt  = '0;
            end
         end
         WR_TAB: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_W'(idx);
            avm_writedata = table_q[idx];
         end
         WR_TIPO: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_W'(TIPO_ADDR);
            avm_writedata = DATA_W'(tipo_q);
         end
         RD_TAB: begin
            avm_read    = 1'b1;
            avm_address = ADDR_W'(idx);
            expected    = table_q[idx];
         end
         RD_TIPO: begin
            avm_read    = 1'b1;
            avm_address = ADDR_W'(TIPO_ADDR);
            expected    = DATA_W'(tipo_q);
         end
         WR_EN: begin
            avm_write     = 1'b1;
            avm_address   = ADDR_W'(ENABLE_ADDR);
            avm_writedata = DATA_W'(enable_q);
         end
         DONE: begin
            o_done    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      if (avm_write || avm_read) begin
         if (avm_waitrequest) begin
            if (wait_cnt == LAST_WAIT) begin
               fail      = 1'b1;
               wait_nxt  = '0;
               state_nxt = DONE;
            end else begin
               wait_nxt = wait_cnt + WAIT_W'(1);
            end
         end else begin
            wait_nxt = '0;
            if (avm_read && (avm_readdata != expected))
               fail = 1'b1;
            case (state)
               WR_TAB: begin
                  if (idx == LAST_IDX) begin
                     idx_nxt   = '0;
                     state_nxt = WR_TIPO;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
               WR_TIPO: state_nxt = verify_q ? RD_TAB : WR_EN;
               RD_TAB: begin
                  if (idx == LAST_IDX) begin
                     idx_nxt   = '0;
                     state_nxt = RD_TIPO;
                  end else begin
                     idx_nxt = idx + IDX_W'(1);
                  end
               end
               // Any mismatch so far, including this last read, suppresses the enable write.
               RD_TIPO: state_nxt = (o_error || fail) ? DONE : WR_EN;
               WR_EN:   state_nxt = DONE;
               default: ;
            endcase
         end
      end
   end

   assign avm_chipselect = avm_write | avm_read;
   assign o_busy         = (state != IDLE) && (state != DONE);

endmodule
